// File: rtl/gpio_defaults_bank.sv
// gpio_defaults_bank: run-time writable per-pad GPIO default words, driven in parallel to the
// pads and serially loadable into the gpio_control_block chain.
module gpio_defaults_bank #(
   parameter int unsigned NUM_GPIO    = 38,
   parameter int unsigned CFG_WIDTH   = 13,
   parameter logic [NUM_GPIO*CFG_WIDTH-1:0] GPIO_CONFIG_INIT = {NUM_GPIO{13'h0402}},
   parameter int unsigned HALF_PERIOD = 1,
   parameter bit          AUTO_XFER   = 1'b1,
   localparam int unsigned AW         = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rstn_i,
   input  logic                          cfg_we,
   input  logic [AW-1:0]                 cfg_addr,
   input  logic [CFG_WIDTH-1:0]          cfg_wdata,
   output logic [CFG_WIDTH-1:0]          cfg_rdata,
   input  logic                          restore,
   input  logic                          xfer_start,
   output logic                          xfer_busy,
   output logic                          xfer_done,
   output logic                          serial_clock,
   output logic                          serial_load,
   output logic                          serial_data,
   output logic [NUM_GPIO*CFG_WIDTH-1:0] gpio_defaults
);

   localparam int unsigned NB = NUM_GPIO * CFG_WIDTH;
   localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(NB - 1);
   localparam logic [PW-1:0] LAST_PH  = PW'(HALF_PERIOD - 1);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SHIFT_LO = 3'd1;
   localparam logic [2:0] SHIFT_HI = 3'd2;
   localparam logic [2:0] GAP      = 3'd3;
   localparam logic [2:0] LOAD     = 3'd4;

   logic [NB-1:0]  cfg_q, cfg_d, shreg_q, shreg_d;
   logic [2:0]     state_q, state_d;
   logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]  phase_q, phase_d;
   logic           busy_q, busy_d, done_q, done_d;
   logic           sclk_q, sclk_d, sload_q, sload_d, sdata_q, sdata_d;
   logic           auto_q, auto_d, armed_q;
   logic           addr_ok, start, phase_end;
   logic [31:0]    word_base;

   assign addr_ok   = (32'(cfg_addr) < NUM_GPIO);
   assign word_base = 32'(cfg_addr) * CFG_WIDTH;
   // armed_q delays the automatic start to the second edge after reset release
   assign start     = xfer_start | (auto_q & armed_q);
   assign phase_end = (phase_q == LAST_PH);

   always_comb begin
      cfg_d = cfg_q;
      if (restore) begin
         cfg_d = GPIO_CONFIG_INIT;
      end else if (cfg_we && addr_ok) begin
         cfg_d[word_base +: CFG_WIDTH] = cfg_wdata;
      end
   end

   assign cfg_rdata = addr_ok ? cfg_q[word_base +: CFG_WIDTH] : '0;

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      phase_d   = phase_q;
      sclk_d    = sclk_q;
      sload_d   = sload_q;
      sdata_d   = sdata_q;
      done_d    = 1'b0;
      auto_d    = auto_q & ~armed_q;
      if (state_q != IDLE) begin
         phase_d = phase_end ? '0 : phase_q + 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               // Snapshot the words; the flat MSB is channel NUM_GPIO-1's MSB, sent first
               state_d   = SHIFT_LO;
               sdata_d   = cfg_q[NB-1];
               shreg_d   = cfg_q << 1;
               bit_cnt_d = '0;
               phase_d   = '0;
               sclk_d    = 1'b0;
            end
         end
         SHIFT_LO: begin
            if (phase_end) begin
               state_d = SHIFT_HI;
               sclk_d  = 1'b1;
            end
         end
         SHIFT_HI: begin
            if (phase_end) begin
               sclk_d = 1'b0;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = GAP;
                  sdata_d = 1'b0;
               end else begin
                  state_d   = SHIFT_LO;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  sdata_d   = shreg_q[NB-1];
                  shreg_d   = shreg_q << 1;
               end
            end
         end
         GAP: begin
            if (phase_end) begin
               state_d = LOAD;
               sload_d = 1'b1;
            end
         end
         LOAD: begin
            if (phase_end) begin
               state_d = IDLE;
               sload_d = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            sclk_d  = 1'b0;
            sload_d = 1'b0;
            sdata_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         cfg_q     <= GPIO_CONFIG_INIT;
         shreg_q   <= '0;
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         phase_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sclk_q    <= 1'b0;
         sload_q   <= 1'b0;
         sdata_q   <= 1'b0;
         auto_q    <= AUTO_XFER;
         armed_q   <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         shreg_q   <= shreg_d;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         phase_q   <= phase_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sclk_q    <= sclk_d;
         sload_q   <= sload_d;
         sdata_q   <= sdata_d;
         auto_q    <= auto_d;
         armed_q   <= 1'b1;
      end
   end

   assign xfer_busy     = busy_q;
   assign xfer_done     = done_q;
   assign serial_clock  = sclk_q;
   assign serial_load   = sload_q;
   assign serial_data   = sdata_q;
   assign gpio_defaults = cfg_q;

endmodule
